// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the PE arithmetic blocks (multiplier and adder).
// Latency: n/a (constants, types and a pure classification function).
// Backpressure: n/a.
package fp_pkg;

    // FP32 field layout
    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int PROD_W   = 2 * MANT_W;
    // Exponent arithmetic is carried as a 10-bit signed value so that both
    // underflow (<= 0) and overflow (>= 255) stay representable.
    localparam int EXPS_W   = 10;

    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

    // Stage-1 register contents: unpacked operands
    typedef struct packed {
        logic                     sign;
        logic signed [EXPS_W-1:0] exp;
        logic [MANT_W-1:0]        mant_a;
        logic [MANT_W-1:0]        mant_b;
        fp_class_t                cls_a;
        fp_class_t                cls_b;
    } fp_mul_s1_t;

    // Stage-2 register contents: raw product plus forwarded metadata
    typedef struct packed {
        logic                     sign;
        logic signed [EXPS_W-1:0] exp;
        logic [PROD_W-1:0]        prod;
        fp_class_t                cls_a;
        fp_class_t                cls_b;
    } fp_mul_s2_t;

    // Denormals are flushed: any zero exponent counts as zero.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        if (x[30:23] == 8'h00) begin
            c = FP_ZERO;
        end else if (x[30:23] == 8'hFF) begin
            c = (x[22:0] == '0) ? FP_INF : FP_NAN;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Normalize, round, overflow/underflow clamp and pack a raw 48-bit mantissa product.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of its inputs.
// Ports: sign_i/exp_i/prod_i = sign, biased 10-bit signed exponent and 24x24 product;
//        result_o = packed fp32. Rounding is RNE when FP_MUL_RNE_EN is defined,
//        truncation (toward zero) otherwise.
module fp_mul_norm_round
    import fp_pkg::*;
(
    input  logic                     sign_i,
    input  logic signed [EXPS_W-1:0] exp_i,
    input  logic [PROD_W-1:0]        prod_i,
    output logic [31:0]              result_o
);

    logic                     round_up;
    logic [MANT_W-1:0]        mant_pre;
    logic signed [EXPS_W-1:0] exp_pre;
    logic [MANT_W:0]          mant_rnd;
    logic [MANT_W-1:0]        mant_fin;
    logic signed [EXPS_W-1:0] exp_fin;

`ifdef FP_MUL_RNE_EN
    logic guard;
    logic sticky;
`else
    // Low product bits only matter for rounding; truncation drops them.
    logic unused_lsbs;
    assign unused_lsbs = ^prod_i[22:0];
`endif

    always_comb begin
        mant_pre = '0;
        exp_pre  = exp_i;
        round_up = 1'b0;
        mant_rnd = '0;
        mant_fin = '0;
        exp_fin  = '0;
        result_o = '0;

        // Product of two [1,2) mantissas lies in [1,4): at most one shift.
        if (prod_i[PROD_W-1]) begin
            mant_pre = prod_i[47:24];
            exp_pre  = exp_i + 10'sd1;
        end else begin
            mant_pre = prod_i[46:23];
            exp_pre  = exp_i;
        end

`ifdef FP_MUL_RNE_EN
        guard    = prod_i[PROD_W-1] ? prod_i[23] : prod_i[22];
        sticky   = prod_i[PROD_W-1] ? (|prod_i[22:0]) : (|prod_i[21:0]);
        round_up = guard & (sticky | mant_pre[0]);
`else
        round_up = 1'b0;
`endif

        mant_rnd = {1'b0, mant_pre} + {{MANT_W{1'b0}}, round_up};

        // All-ones mantissa rounding up wraps to 1.0 at the next exponent.
        if (mant_rnd[MANT_W]) begin
            mant_fin = {1'b1, {FRAC_W{1'b0}}};
            exp_fin  = exp_pre + 10'sd1;
        end else begin
            mant_fin = mant_rnd[MANT_W-1:0];
            exp_fin  = exp_pre;
        end

        if (exp_fin >= $signed(10'(EXP_MAX))) begin
            result_o = {sign_i, PINF[30:0]};
        end else if (exp_fin <= 10'sd0) begin
            result_o = {sign_i, 31'b0};
        end else begin
            result_o = {sign_i, exp_fin[EXP_W-1:0], mant_fin[FRAC_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_mul.sv
// Pipelined IEEE-754 binary32 multiplier feeding the PE accumulator adder.
// Latency: 3 en-high clock edges from operand capture to PE_result/out_valid.
// Backpressure: none beyond en; en=0 freezes every stage including valids.
// Ports: clk, rst (synchronous, active-low), en (global advance), in_valid/PE_a/PE_b
//        (operand pair), PE_result/out_valid (registered product and its valid).
// Config: define FP_MUL_RNE_EN for round-to-nearest-even, otherwise truncation.
module fp_mul #(
    parameter int          BIAS      = fp_pkg::BIAS,
    parameter logic [31:0] NAN_CANON = fp_pkg::QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] PE_a,
    input  logic [31:0] PE_b,
    output logic [31:0] PE_result,
    output logic        out_valid
);

    import fp_pkg::*;

    fp_mul_s1_t  s1_d, s1_q;
    fp_mul_s2_t  s2_d, s2_q;
    logic        vld1_d, vld1_q;
    logic        vld2_d, vld2_q;
    logic [31:0] result_d, result_q;
    logic        out_valid_d, out_valid_q;

    logic [31:0] norm_res;
    logic        any_nan;
    logic        any_inf;
    logic        any_zero;

    // S1: unpack and classify
    always_comb begin
        s1_d        = '0;
        vld1_d      = in_valid;
        s1_d.sign   = PE_a[SIGN_BIT] ^ PE_b[SIGN_BIT];
        s1_d.cls_a  = fp_classify(PE_a);
        s1_d.cls_b  = fp_classify(PE_b);
        // Modular 10-bit arithmetic gives the correct two's-complement result.
        s1_d.exp    = 10'(PE_a[30:23]) + 10'(PE_b[30:23]) - 10'(BIAS);
        s1_d.mant_a = (s1_d.cls_a == FP_NORM) ? {1'b1, PE_a[FRAC_W-1:0]} : '0;
        s1_d.mant_b = (s1_d.cls_b == FP_NORM) ? {1'b1, PE_b[FRAC_W-1:0]} : '0;
    end

    // S2: mantissa multiply, metadata forwarded
    always_comb begin
        s2_d       = '0;
        vld2_d     = vld1_q;
        s2_d.sign  = s1_q.sign;
        s2_d.exp   = s1_q.exp;
        s2_d.cls_a = s1_q.cls_a;
        s2_d.cls_b = s1_q.cls_b;
        s2_d.prod  = 48'(s1_q.mant_a) * 48'(s1_q.mant_b);
    end

    // S3: normal path through the shared normalize/round block
    fp_mul_norm_round u_norm_round (
        .sign_i   (s2_q.sign),
        .exp_i    (s2_q.exp),
        .prod_i   (s2_q.prod),
        .result_o (norm_res)
    );

    // S3: special-case priority NaN > inf > zero > normal
    always_comb begin
        any_inf     = (s2_q.cls_a == FP_INF)  || (s2_q.cls_b == FP_INF);
        any_zero    = (s2_q.cls_a == FP_ZERO) || (s2_q.cls_b == FP_ZERO);
        any_nan     = (s2_q.cls_a == FP_NAN)  || (s2_q.cls_b == FP_NAN) ||
                      (any_inf && any_zero);
        out_valid_d = vld2_q;
        if (any_nan) begin
            result_d = NAN_CANON;
        end else if (any_inf) begin
            result_d = {s2_q.sign, PINF[30:0]};
        end else if (any_zero) begin
            result_d = {s2_q.sign, 31'b0};
        end else begin
            result_d = norm_res;
        end
    end

    // Reset wins over en; en=0 holds every stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            vld1_q      <= vld1_d;
            vld2_q      <= vld2_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign PE_result = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fp_mul.sv
module tb_fp_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] PE_a;
    logic [31:0] PE_b;
    logic [31:0] PE_result;
    logic        out_valid;

    always #5 clk = ~clk;

    fp_mul dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .PE_a      (PE_a),
        .PE_b      (PE_b),
        .PE_result (PE_result),
        .out_valid (out_valid)
    );

    typedef struct {
        logic [31:0] res;
        int          tag;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[$];
    logic [31:0] exp_in;
    int          adv_cnt   = 0;
    bit          last_en   = 1'b0;
    bit          last_rst  = 1'b0;
    bit          last_adv  = 1'b0;
    logic [31:0] prev_res;
    logic        prev_vld;
    int          n_checks  = 0;
    int          n_fail    = 0;

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
    localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Capture side: every pair accepted on an advancing edge gets its expected
    // result queued, tagged with the advance count at capture.
    always @(posedge clk) begin
        last_en  = en;
        last_rst = rst;
        last_adv = rst && en;
        if (!rst) begin
            sb_q.delete();
        end else if (en) begin
            if (in_valid) sb_q.push_back('{exp_in, adv_cnt});
            adv_cnt++;
        end
    end

    // Monitor: one pop per advancing edge that shows out_valid; stalled edges
    // must leave the outputs exactly as they were.
    always @(negedge clk) begin
        sb_t e;
        if (last_rst && !last_en) begin
            check32("stall_hold_result", PE_result, prev_res);
            check32("stall_hold_valid", {31'b0, out_valid}, {31'b0, prev_vld});
        end else if (last_adv && out_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with out_valid=1, expected no output (t=%0t)",
                         PE_result, $time);
            end else begin
                e = sb_q.pop_front();
                check32("result", PE_result, e.res);
                check32("latency", 32'(adv_cnt - e.tag), 32'd3);
            end
        end
        prev_res = PE_result;
        prev_vld = out_valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        in_valid = 1'b1;
        PE_a     = a;
        PE_b     = b;
        exp_in   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && cnt < 50) begin
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        check32("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        PE_a     = 32'h0;
        PE_b     = 32'h0;
        exp_in   = 32'h0;

        vecs.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000}); // 2*3
        vecs.push_back('{32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000}); // -1.5*2
        vecs.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000}); // overflow
        vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000}); // inf*0
        vecs.push_back('{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000}); // -inf*1
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000}); // denormal
        vecs.push_back('{32'h0080_0000, 32'h0080_0000, 32'h0000_0000}); // underflow
        vecs.push_back('{32'h3FC0_0001, 32'h3FC0_0001, RND_EXP});       // rounding
        vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000}); // NaN in
        vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000}); // -0*1
        vecs.push_back('{32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000}); // inf*-1
        vecs.push_back('{32'hFF80_0001, 32'h0000_0000, 32'h7FC0_0000}); // NaN*0
        vecs.push_back('{32'h7F80_0000, 32'h0000_0001, 32'h7FC0_0000}); // inf*denormal
        vecs.push_back('{32'h2000_0000, 32'h1F80_0000, 32'h0000_0000}); // exp exactly 0
        vecs.push_back('{32'h2000_0000, 32'h2000_0000, 32'h0080_0000}); // smallest normal
        vecs.push_back('{32'h7F00_0000, 32'h3FFF_FFFF, 32'h7F7F_FFFF}); // largest finite
        vecs.push_back('{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE}); // no round-up

        // Reset with en low: reset has priority.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset_result", PE_result, 32'h0);
        check32("reset_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b1;

        // Back-to-back directed vectors.
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].e);

        // Stall while earlier results are still emerging.
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        en       = 1'b0;
        in_valid = 1'b1;
        PE_a     = 32'hDEAD_BEEF;
        PE_b     = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        issue(32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
        issue(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000);
        drain();

        // Reset while three pairs are in flight: none may ever appear.
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        issue(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
        in_valid = 1'b1;
        PE_a     = 32'h3F80_0000;
        PE_b     = 32'h4000_0000;
        exp_in   = 32'h4000_0000;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check32("midreset_result", PE_result, 32'h0);
        check32("midreset_valid", {31'b0, out_valid}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32("post_reset_no_valid", {31'b0, out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Pipeline works again after reset.
        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
